// File: rtl/uart_out_pkg.sv
// rtl/uart_out_pkg.sv - shared state encodings and frame constants for the UART transmitter
package uart_out_pkg;

  // Link-level states, shared with the receive side of the same link.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  localparam int DATA_BITS        = 8;
  localparam int DIV_SIZE_DEFAULT = 10416;
  localparam int BAUD_W           = 32;
  localparam int BIT_W            = 4;

  // Parity over one data byte; odd selects odd parity.
  function automatic logic frame_parity(input logic [DATA_BITS-1:0] b, input logic odd);
    return (^b) ^ odd;
  endfunction

endpackage

// File: rtl/uart_out_up_counter.sv
// rtl/uart_out_up_counter.sv - free-running up counter with synchronous clear and enable
module uart_out_up_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  // Clear wins over increment so a boundary cycle always restarts at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/uart_out.sv
// rtl/uart_out.sv - 8-bit UART transmitter with one-entry holding register
module uart_out
  import uart_out_pkg::*;
#(
  parameter int DIV_SIZE   = DIV_SIZE_DEFAULT,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 send,
  output logic                 ready,
  output logic                 srl_out,
  output logic                 busy,
  output logic                 xmit_done
);

  uart_state_t          state;
  uart_state_t          state_nx;
  logic [BAUD_W-1:0]    baud_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic                 baud_clr;
  logic                 bit_clr;
  logic                 bit_end;
  logic                 last_bit;
  logic                 accept;
  logic                 load;
  logic [DATA_BITS-1:0] load_src;
  logic [DATA_BITS-1:0] hold_data;
  logic                 hold_full;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] shift_nx;
  logic                 par_q;
  logic                 srl_d;

  // A byte is taken whenever the holding slot is free.
  assign accept   = send && !hold_full;
  assign bit_end  = (state != ST_IDLE) && (baud_cnt == BAUD_W'(DIV_SIZE - 1));
  assign baud_clr = (state == ST_IDLE) || bit_end;
  assign bit_clr  = (state == ST_IDLE) || (bit_end && last_bit);
  // Entering START from IDLE or STOP is the only moment the shift register loads.
  assign load     = (state_nx == ST_START) && (state != ST_START);
  // In IDLE an accepted byte bypasses the holding slot and goes straight to the shifter.
  assign load_src = hold_full ? hold_data : data_in;

  uart_out_up_counter #(.WIDTH(BAUD_W)) u_baud_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (baud_clr),
    .en    (1'b1),
    .count (baud_cnt)
  );

  uart_out_up_counter #(.WIDTH(BIT_W)) u_bit_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (bit_clr),
    .en    (bit_end),
    .count (bit_cnt)
  );

  // Marks the final bit period of the multi-bit states.
  always_comb begin
    last_bit = 1'b1;
    case (state)
      ST_DATA: last_bit = (bit_cnt == BIT_W'(DATA_BITS - 1));
      ST_STOP: last_bit = (bit_cnt == BIT_W'(STOP_BITS - 1));
      default: last_bit = 1'b1;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; a full holding slot chains frames with no idle gap.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (hold_full || accept) state_nx = ST_START;
      ST_START:  if (bit_end) state_nx = ST_DATA;
      ST_DATA:   if (bit_end && last_bit) state_nx = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (bit_end) state_nx = ST_STOP;
      ST_STOP:   if (bit_end && last_bit) state_nx = hold_full ? ST_START : ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Output logic: line value is chosen for the upcoming state so srl_out can be registered.
  always_comb begin
    shift_nx = shift_q;
    if (load) begin
      shift_nx = load_src;
    end else if ((state == ST_DATA) && bit_end) begin
      shift_nx = {1'b0, shift_q[DATA_BITS-1:1]};
    end
    srl_d = 1'b1;
    case (state_nx)
      ST_START:  srl_d = 1'b0;
      ST_DATA:   srl_d = shift_nx[0];
      ST_PARITY: srl_d = par_q;
      default:   srl_d = 1'b1;
    endcase
  end

  assign ready     = !hold_full;
  assign busy      = (state != ST_IDLE);
  assign xmit_done = (state == ST_STOP) && bit_end && last_bit;

  // Datapath registers: shifter, latched parity, line driver and holding slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q   <= '0;
      par_q     <= 1'b0;
      srl_out   <= 1'b1;
      hold_full <= 1'b0;
      hold_data <= '0;
    end else begin
      shift_q <= shift_nx;
      srl_out <= srl_d;
      if (load) begin
        par_q <= frame_parity(load_src, PARITY_ODD != 0);
      end
      if (load && hold_full) begin
        hold_full <= 1'b0;
      end else if (accept && (state != ST_IDLE)) begin
        hold_full <= 1'b1;
        hold_data <= data_in;
      end
    end
  end

endmodule

// File: tb/tb_uart_out.sv
// tb/tb_uart_out.sv - directed self-checking bench for uart_out
module tb_uart_out;

  localparam int NLB = 256;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] send = '0;
  logic [7:0] din [4];
  logic [3:0] ready;
  logic [3:0] srl;
  logic [3:0] busy;
  logic [3:0] done;
  logic [7:0] lb_q [$];
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  uart_out #(.DIV_SIZE(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst(rst), .data_in(din[0]), .send(send[0]),
    .ready(ready[0]), .srl_out(srl[0]), .busy(busy[0]), .xmit_done(done[0]));
  uart_out #(.DIV_SIZE(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst(rst), .data_in(din[1]), .send(send[1]),
    .ready(ready[1]), .srl_out(srl[1]), .busy(busy[1]), .xmit_done(done[1]));
  uart_out #(.DIV_SIZE(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .rst(rst), .data_in(din[2]), .send(send[2]),
    .ready(ready[2]), .srl_out(srl[2]), .busy(busy[2]), .xmit_done(done[2]));
  uart_out #(.DIV_SIZE(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_8n2 (
    .clk(clk), .rst(rst), .data_in(din[3]), .send(send[3]),
    .ready(ready[3]), .srl_out(srl[3]), .busy(busy[3]), .xmit_done(done[3]));

  // One-cycle send pulse; caller is positioned 1 time unit after an edge.
  task automatic kick(input int idx, input logic [7:0] b);
    send[idx] = 1'b1;
    din[idx]  = b;
    @(posedge clk); #1;
    send[idx] = 1'b0;
  endtask

  // Records the line once per bit period plus done/busy/ready traces; optionally holds send high.
  task automatic capture(input int idx, input int ncyc, input int inj_from, input int inj_to,
                         input logic [7:0] inj_data, output logic [31:0] bits, output int glitches,
                         output int dcnt, output int dlast, output int bcnt, output logic [127:0] rdy);
    bits = '0; glitches = 0; dcnt = 0; dlast = -1; bcnt = 0; rdy = '0;
    for (int k = 0; k < ncyc; k++) begin
      send[idx] = (k >= inj_from) && (k <= inj_to);
      din[idx]  = (k == inj_from) ? inj_data : (inj_data ^ 8'(k));
      if (k % 4 == 0) bits[k/4] = srl[idx];
      else if (srl[idx] !== bits[k/4]) glitches++;
      if (done[idx] === 1'b1) begin dcnt++; dlast = k + 1; end
      if (busy[idx] === 1'b1) bcnt++;
      rdy[k] = ready[idx];
      @(posedge clk); #1;
    end
    send[idx] = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    total++; if (srl !== 4'hF) begin bad++; $display("FAIL reset_srl got=%b want=1111", srl); end
    total++; if (ready !== 4'hF) begin bad++; $display("FAIL reset_ready got=%b want=1111", ready); end
    total++; if (busy !== 4'h0) begin bad++; $display("FAIL reset_busy got=%b want=0000", busy); end
    total++; if (done !== 4'h0) begin bad++; $display("FAIL reset_done got=%b want=0000", done); end
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic test_single();
    logic [31:0] bits; int g, dc, dl, bc; logic [127:0] rdy;
    total++; if (ready[0] !== 1'b1) begin bad++; $display("FAIL single_ready got=%b want=1", ready[0]); end
    kick(0, 8'hA5);
    capture(0, 44, -1, -2, 8'h00, bits, g, dc, dl, bc, rdy);
    total++; if (bits[10:0] !== {1'b1, 1'b1, 8'hA5, 1'b0})
      begin bad++; $display("FAIL single_bits got=%h want=%h", bits[10:0], {1'b1, 1'b1, 8'hA5, 1'b0}); end
    total++; if (g !== 0) begin bad++; $display("FAIL single_glitch got=%0d want=0", g); end
    total++; if (dc !== 1 || dl !== 40) begin bad++; $display("FAIL single_done got=%0d@%0d want=1@40", dc, dl); end
    total++; if (bc !== 40) begin bad++; $display("FAIL single_busy got=%0d want=40", bc); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] bits; int g, dc, dl, bc; logic [127:0] rdy;
    kick(0, 8'h00);
    capture(0, 84, 8, 8, 8'hFF, bits, g, dc, dl, bc, rdy);
    total++; if (bits[20:0] !== {1'b1, 1'b1, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b0})
      begin bad++; $display("FAIL b2b_bits got=%h want=%h", bits[20:0], {1'b1, 1'b1, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b0}); end
    total++; if ({rdy[8], rdy[9], rdy[39], rdy[40]} !== 4'b1001)
      begin bad++; $display("FAIL b2b_ready got=%b want=1001", {rdy[8], rdy[9], rdy[39], rdy[40]}); end
    total++; if (bc !== 80) begin bad++; $display("FAIL b2b_busy got=%0d want=80", bc); end
    total++; if (dc !== 2 || g !== 0) begin bad++; $display("FAIL b2b_done_glitch got=%0d/%0d want=2/0", dc, g); end
  endtask

  task automatic test_overrun();
    logic [31:0] bits; int g, dc, dl, bc; logic [127:0] rdy;
    kick(0, 8'h11);
    capture(0, 100, 4, 30, 8'h22, bits, g, dc, dl, bc, rdy);
    total++; if (bits[24:0] !== {5'h1F, 1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 1'b0})
      begin bad++; $display("FAIL overrun_bits got=%h want=%h", bits[24:0], {5'h1F, 1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 1'b0}); end
    total++; if (dc !== 2 || bc !== 80) begin bad++; $display("FAIL overrun_done_busy got=%0d/%0d want=2/80", dc, bc); end
  endtask

  task automatic test_parity();
    logic [31:0] bits; int g, dc, dl, bc; logic [127:0] rdy;
    kick(1, 8'h07);
    capture(1, 48, -1, -2, 8'h00, bits, g, dc, dl, bc, rdy);
    total++; if (bits[11:0] !== {1'b1, 1'b1, 1'b1, 8'h07, 1'b0})
      begin bad++; $display("FAIL parity_even_bits got=%h want=%h", bits[11:0], {1'b1, 1'b1, 1'b1, 8'h07, 1'b0}); end
    total++; if (dl !== 44 || bc !== 44) begin bad++; $display("FAIL parity_even_len got=%0d/%0d want=44/44", dl, bc); end
    kick(2, 8'h07);
    capture(2, 48, -1, -2, 8'h00, bits, g, dc, dl, bc, rdy);
    total++; if (bits[11:0] !== {1'b1, 1'b1, 1'b0, 8'h07, 1'b0})
      begin bad++; $display("FAIL parity_odd_bits got=%h want=%h", bits[11:0], {1'b1, 1'b1, 1'b0, 8'h07, 1'b0}); end
    total++; if (dl !== 44 || g !== 0) begin bad++; $display("FAIL parity_odd_len got=%0d/%0d want=44/0", dl, g); end
  endtask

  task automatic test_stop2();
    logic [31:0] bits; int g, dc, dl, bc; logic [127:0] rdy;
    kick(3, 8'h3C);
    capture(3, 48, -1, -2, 8'h00, bits, g, dc, dl, bc, rdy);
    total++; if (bits[11:0] !== {1'b1, 2'b11, 8'h3C, 1'b0})
      begin bad++; $display("FAIL stop2_bits got=%h want=%h", bits[11:0], {1'b1, 2'b11, 8'h3C, 1'b0}); end
    total++; if (dc !== 1 || dl !== 44 || bc !== 44)
      begin bad++; $display("FAIL stop2_done got=%0d@%0d busy=%0d want=1@44 busy=44", dc, dl, bc); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] bits; int g, dc, dl, bc; logic [127:0] rdy;
    kick(0, 8'hC3);
    capture(0, 12, 6, 6, 8'h99, bits, g, dc, dl, bc, rdy);
    total++; if (ready[0] !== 1'b0) begin bad++; $display("FAIL rstmid_pending got=%b want=0", ready[0]); end
    #2 rst = 1'b1;
    #1;
    total++; if ({srl[0], ready[0], busy[0]} !== 3'b110)
      begin bad++; $display("FAIL rstmid_async got=%b want=110", {srl[0], ready[0], busy[0]}); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    kick(0, 8'h5A);
    capture(0, 60, -1, -2, 8'h00, bits, g, dc, dl, bc, rdy);
    total++; if (bits[14:0] !== {5'h1F, 1'b1, 8'h5A, 1'b0})
      begin bad++; $display("FAIL rstmid_frame got=%h want=%h", bits[14:0], {5'h1F, 1'b1, 8'h5A, 1'b0}); end
    total++; if (dc !== 1) begin bad++; $display("FAIL rstmid_done got=%0d want=1", dc); end
  endtask

  task automatic test_loopback();
    int rx_n;
    rx_n = 0;
    lb_q.delete();
    fork
      begin : feeder
        int w;
        logic [7:0] b;
        for (int n = 0; n < NLB; n++) begin
          b = 8'($urandom_range(0, 255));
          send[0] = 1'b1;
          din[0]  = b;
          w = 0;
          while (ready[0] !== 1'b1 && w < 200) begin @(posedge clk); #1; w++; end
          if (w >= 200) begin
            total++; bad++; $display("FAIL loopback_feed got=timeout want=ready n=%0d", n);
            break;
          end
          lb_q.push_back(b);
          @(posedge clk); #1;
        end
        send[0] = 1'b0;
      end
      begin : receiver
        int w;
        logic [7:0] rb;
        logic [7:0] eb;
        for (int n = 0; n < NLB; n++) begin
          w = 0;
          while (srl[0] !== 1'b0 && w < 200) begin @(posedge clk); #1; w++; end
          if (w >= 200) begin
            total++; bad++; $display("FAIL loopback_start got=timeout want=start n=%0d", n);
            break;
          end
          for (int j = 0; j < 8; j++) begin
            repeat ((j == 0) ? 6 : 4) begin @(posedge clk); #1; end
            rb[j] = srl[0];
          end
          repeat (4) begin @(posedge clk); #1; end
          eb = (lb_q.size() > 0) ? lb_q.pop_front() : ~rb;
          total++; if (rb !== eb || srl[0] !== 1'b1)
            begin bad++; $display("FAIL loopback_byte n=%0d got=%h stop=%b want=%h stop=1", n, rb, srl[0], eb); end
          rx_n++;
        end
      end
    join
    total++; if (rx_n !== NLB) begin bad++; $display("FAIL loopback_count got=%0d want=%0d", rx_n, NLB); end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) din[i] = 8'h00;
    test_reset();
    test_single();
    repeat (3) begin @(posedge clk); #1; end
    test_back_to_back();
    test_overrun();
    test_parity();
    test_stop2();
    test_reset_mid();
    test_loopback();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
